cdb_writeback: RTL
==================

Name: cdb_writeback

Overview:
- Complete-stage writeback transmitter. Feeds the physical register file write port and the CDB tag broadcast.
- Collects results from NUM_FU functional units into per-FU holding buffers.
- Round-robin arbitrates one result per cycle and drives a registered write/broadcast packet (write_en, write_tag, write_data, rob_idx).
- Sits between execute and the PRF/RS/ROB wakeup logic.

Parameters:
- NUM_FU, 4, number of functional-unit result sources (>=2).
- DEPTH, 2, entries per FU holding buffer (power of 2, >=2).
- TAG_W, $clog2(`PHYS_REG_SZ), physical register tag width.
- ROB_W, 5, ROB index width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- squash  in  1  mispredict flush, synchronous
- fu_valid  in  NUM_FU  result valid per FU
- fu_tag  in  NUM_FU*TAG_W  destination phys reg per FU
- fu_data  in  NUM_FU*`XLEN  result value per FU
- fu_rob_idx  in  NUM_FU*ROB_W  ROB entry per FU
- fu_ready  out  NUM_FU  buffer can accept this cycle
- cdb_valid  out  1  broadcast valid (ROB complete, RS wakeup)
- cdb_tag  out  TAG_W  broadcast tag
- cdb_data  out  `XLEN  broadcast value
- cdb_rob_idx  out  ROB_W  completing ROB entry
- prf_write_en  out  1  PRF write enable (= cdb_valid && cdb_tag != 0)

Behaviour:
- Reset: all buffers empty; counts 0; rr_ptr=0. Outputs cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_rob_idx=0, prf_write_en=0. fu_ready is all-ones in the cycle after reset.
- Buffers: one FIFO per FU with head/tail pointers that wrap mod DEPTH.
  - fu_ready[i] = (count[i] != DEPTH), taken from the current count only. No same-cycle pop credit.
  - Enqueue when fu_valid[i] && fu_ready[i].
  - fu_valid while not ready is a protocol error: the entry is dropped and an assertion fires.
- Arbitration (combinational, each cycle):
  - Scan from rr_ptr upward, modulo NUM_FU, for the first non-empty buffer g.
  - Pop the head of g and register it into the output registers.
  - After a grant, rr_ptr <= (g+1) mod NUM_FU. With no grant, rr_ptr is unchanged and cdb_valid <= 0.
- Latency: result accepted at edge E is in the buffer after E. If granted, it is visible on cdb_* after E+1, i.e. 2 cycles.
- Throughput: exactly one broadcast per cycle maximum. No backpressure from the PRF or CDB.
- Enqueue and pop on the same buffer in the same cycle: count unchanged. Full buffer: no enqueue (ready low), pop allowed.
- Tag 0: cdb_valid=1 (ROB still completes), prf_write_en=0, cdb_tag=0.
- squash, evaluated before the enqueue/pop logic:
  - All counts and pointers clear; same-cycle enqueues are discarded.
  - Output registers clear next edge (cdb_valid=0, prf_write_en=0).
  - rr_ptr is preserved.
- reset has priority over squash. Reset asserted mid-operation discards all buffered results.
- Output registers hold their values between grants; data/tag are don't-care when cdb_valid=0 but are driven from the last grant.

Optional Feature:
- CDB_BYPASS_EN defined: an FU whose buffer is empty may join arbitration in its arrival cycle with its incoming packet.
  - If granted, it goes straight to the output registers and is not enqueued. Latency is 1 cycle.
  - Round-robin ordering is unchanged.
- Undefined: every result passes through its buffer; minimum latency is 2 cycles.

Decomposition:
- Shared package (sys_defs.svh) gets:
  - typedef CDB_PACKET {valid, tag (PHYS_REG_TAG), data[`XLEN], rob_idx}.
  - typedef FU_CDB_PACKET {valid, tag, data, rob_idx}.
  - constants NUM_FU and CDB_BUF_DEPTH.
- Sub-module cdb_fu_fifo, one instance per FU: enqueue/pop/flush, count, head packet, ready.
- Arbiter and output registers stay in cdb_writeback.

Test Plan:
- Single FU: reset, then fu_valid[0]=1, tag=5, data=32'hDEAD_BEEF, rob=3 for 1 cycle -> two edges later cdb_valid=1, prf_write_en=1, tag=5, data=DEADBEEF, rob=3 for exactly 1 cycle.
- Contention: all 4 FUs valid in the same cycle (tags 1,2,3,4), rr_ptr=0 -> broadcasts tag order 1,2,3,4 on 4 consecutive cycles; rr_ptr ends at 0.
- Full/backpressure: DEPTH=2, FU1 valid 3 consecutive cycles while FU0 is held at 1 entry per cycle.
  - fu_ready[1] deasserts when count=2.
  - No entry is lost or duplicated: every accepted tag is broadcast once.
- Tag 0: FU2 sends tag=0, rob=7 -> cdb_valid=1, prf_write_en=0, rob=7.
- Squash: 3 entries buffered across FUs, squash pulsed 1 cycle with FU3 also valid -> next cycle cdb_valid=0; no later broadcast of any of those 4 results; fu_ready all 1.
- CDB_BYPASS_EN: empty buffers, FU0 valid tag=9 at edge E -> cdb_valid=1, tag=9 after edge E (1 cycle). Without the macro the same stimulus gives 2 cycles.

Source files
------------

// File: rtl/cdb_writeback_pkg.sv
// -----------------------------------------------------------------------------
// cdb_writeback_pkg
//   Shared definitions for the complete-stage writeback path: machine widths,
//   default sizing of the writeback block, and the packet shapes moved from
//   the functional units onto the common data bus.
//
//   Configuration macro: CDB_BYPASS_EN (consumed by cdb_writeback). When it is
//   defined, an FU with an empty holding buffer may be granted directly in its
//   arrival cycle.
// -----------------------------------------------------------------------------
package cdb_writeback_pkg;

  localparam int XLEN           = 32;
  localparam int PHYS_REG_SZ    = 64;
  localparam int PHYS_REG_TAG_W = $clog2(PHYS_REG_SZ);
  localparam int ROB_IDX_W      = 5;

  // Default writeback sizing: number of FU result sources and per-FU buffer depth.
  localparam int CDB_NUM_FU     = 4;
  localparam int CDB_BUF_DEPTH  = 2;

  typedef logic [PHYS_REG_TAG_W-1:0] phys_reg_tag_t;

  // Broadcast packet as seen by the PRF / RS / ROB.
  typedef struct packed {
    logic                 valid;
    phys_reg_tag_t        tag;
    logic [XLEN-1:0]      data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } cdb_packet_t;

  // Result packet produced by one functional unit.
  typedef struct packed {
    logic                 valid;
    phys_reg_tag_t        tag;
    logic [XLEN-1:0]      data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } fu_cdb_packet_t;

endpackage

// File: rtl/cdb_fu_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fu_fifo
//   Per-FU result holding buffer. Circular FIFO of DEPTH packed entries with
//   head/tail pointers that wrap modulo DEPTH.
//
//   Ports:
//     clock, reset  system clock, synchronous active-high reset
//     flush         clear all entries (mispredict squash); wins over enq/deq
//     enq, enq_pkt  push a packet (caller guarantees ready)
//     deq           pop the head entry (caller guarantees !empty)
//     head_pkt      packet at the head of the queue
//     empty         no entries held
//     ready         buffer has space, from the current count only
// -----------------------------------------------------------------------------
module cdb_fu_fifo #(
  parameter int DEPTH = 2,
  parameter int PKT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             enq,
  input  logic [PKT_W-1:0] enq_pkt,
  input  logic             deq,
  output logic [PKT_W-1:0] head_pkt,
  output logic             empty,
  output logic             ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PKT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mem_we;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_we  = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointer increments wrap naturally.
      if (enq) begin
        mem_we = 1'b1;
        tail_d = tail_q + 1'b1;
      end
      if (deq) begin
        head_d = head_q + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; validity is tracked entirely by count_q.
  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem_q[tail_q] <= enq_pkt;
    end
  end

  assign head_pkt = mem_q[head_q];
  assign empty    = (count_q == '0);
  assign ready    = (count_q != CNT_W'(DEPTH));

endmodule

// File: rtl/cdb_writeback.sv
// -----------------------------------------------------------------------------
// cdb_writeback
//   Complete-stage writeback transmitter. Collects results from NUM_FU
//   functional units into per-FU holding buffers, round-robin arbitrates one
//   result per cycle and drives a registered CDB broadcast / PRF write packet.
//
//   Ports:
//     clock, reset          system clock, synchronous active-high reset
//     squash                mispredict flush: empties buffers, clears outputs
//     fu_valid/tag/data/rob_idx  per-FU result inputs (flattened, FU0 in LSBs)
//     fu_ready              per-FU buffer has space this cycle
//     cdb_valid/tag/data/rob_idx  registered broadcast packet
//     prf_write_en          cdb_valid with a non-zero destination tag
//
//   Configuration macro: CDB_BYPASS_EN. When defined, an FU whose buffer is
//   empty competes in its arrival cycle with its incoming packet; a granted
//   bypass goes straight to the output registers (1-cycle latency). When
//   undefined every result passes through its buffer (2-cycle minimum).
// -----------------------------------------------------------------------------
module cdb_writeback
  import cdb_writeback_pkg::*;
#(
  parameter int NUM_FU = CDB_NUM_FU,
  parameter int DEPTH  = CDB_BUF_DEPTH,
  parameter int TAG_W  = PHYS_REG_TAG_W,
  parameter int ROB_W  = ROB_IDX_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       fu_valid,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic [NUM_FU*XLEN-1:0]  fu_data,
  input  logic [NUM_FU*ROB_W-1:0] fu_rob_idx,
  output logic [NUM_FU-1:0]       fu_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [XLEN-1:0]         cdb_data,
  output logic [ROB_W-1:0]        cdb_rob_idx,
  output logic                    prf_write_en
);

  localparam int RR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
    logic [ROB_W-1:0] rob_idx;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);

  pkt_t             in_pkt   [NUM_FU];
  logic [PKT_W-1:0] head_raw [NUM_FU];
  logic [NUM_FU-1:0] buf_empty;
  logic [NUM_FU-1:0] enq;
  logic [NUM_FU-1:0] deq;
  logic [NUM_FU-1:0] cand;
  logic [NUM_FU-1:0] bypass_vec;

  logic             grant_vld;
  logic [RR_W-1:0]  grant_idx;
  pkt_t             grant_pkt;

  logic [RR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             cdb_valid_q, cdb_valid_d;
  logic             prf_we_q, prf_we_d;
  pkt_t             cdb_pkt_q, cdb_pkt_d;

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      in_pkt[i].tag     = fu_tag[i*TAG_W +: TAG_W];
      in_pkt[i].data    = fu_data[i*XLEN +: XLEN];
      in_pkt[i].rob_idx = fu_rob_idx[i*ROB_W +: ROB_W];
    end
  end

  // ---------------------------------------------------------------------------
  // Per-FU holding buffers
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    cdb_fu_fifo #(
      .DEPTH (DEPTH),
      .PKT_W (PKT_W)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .flush    (squash),
      .enq      (enq[i]),
      .enq_pkt  (in_pkt[i]),
      .deq      (deq[i]),
      .head_pkt (head_raw[i]),
      .empty    (buf_empty[i]),
      .ready    (fu_ready[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: first candidate at or above rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    idx  = 0;
    cand = ~buf_empty;
`ifdef CDB_BYPASS_EN
    // An empty buffer can still compete with the packet arriving this cycle.
    cand = cand | (fu_valid & buf_empty);
`endif
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!grant_vld && cand[RR_W'(idx)]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(idx);
      end
    end
    // Squash kills the grant so nothing leaves a buffer being flushed.
    if (squash) grant_vld = 1'b0;
  end

  always_comb begin
    bypass_vec = '0;
`ifdef CDB_BYPASS_EN
    if (grant_vld && buf_empty[grant_idx]) bypass_vec[grant_idx] = 1'b1;
`endif
    deq = '0;
    if (grant_vld && !bypass_vec[grant_idx]) deq[grant_idx] = 1'b1;
    // A bypassed packet is consumed directly and must not also be buffered.
    enq = squash ? '0 : (fu_valid & fu_ready & ~bypass_vec);
    grant_pkt = bypass_vec[grant_idx] ? in_pkt[grant_idx] : pkt_t'(head_raw[grant_idx]);
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = 1'b0;
    prf_we_d    = 1'b0;
    cdb_pkt_d   = cdb_pkt_q;
    if (squash) begin
      cdb_pkt_d = '0;
    end else if (grant_vld) begin
      cdb_valid_d = 1'b1;
      cdb_pkt_d   = grant_pkt;
      // Tag 0 is the architectural zero register: complete in the ROB but never write the PRF.
      prf_we_d    = (grant_pkt.tag != '0);
      rr_ptr_d    = (grant_idx == RR_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers and round-robin pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      prf_we_q    <= 1'b0;
      cdb_pkt_q   <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      prf_we_q    <= prf_we_d;
      cdb_pkt_q   <= cdb_pkt_d;
    end
  end

  assign cdb_valid    = cdb_valid_q;
  assign cdb_tag      = cdb_pkt_q.tag;
  assign cdb_data     = cdb_pkt_q.data;
  assign cdb_rob_idx  = cdb_pkt_q.rob_idx;
  assign prf_write_en = prf_we_q;

`ifndef SYNTHESIS
  // A result offered to a full buffer is dropped; the producer broke the handshake.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_proto_chk
    a_no_drop: assert property (@(posedge clock) disable iff (reset)
                                !(fu_valid[i] && !fu_ready[i]))
      else $error("cdb_writeback: FU %0d result offered while buffer full", i);
  end
`endif

endmodule
